// File: rtl/pipelined_exec_unit.sv
// Forwarded execute back-end: regfile, ID/EX, EX/WB, ALU and halt/drain control.
// Latency: accept at edge k -> wb_valid after k+1 -> regfile write at k+2; in_ready drops once a halt is accepted.
module pipelined_exec_unit #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 4,
  parameter int REG_AW   = $clog2(NUM_REGS),
  parameter int IMM_W    = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [REG_AW-1:0] in_rs,
  input  logic [REG_AW-1:0] in_rt,
  input  logic [REG_AW-1:0] in_rd,
  input  logic [IMM_W-1:0]  in_imm,
  input  logic              in_use_imm,
  input  logic [2:0]        in_alu_op,
  input  logic              in_reg_write,
  input  logic              in_halt,
  output logic              wb_valid,
  output logic [REG_AW-1:0] wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic              wb_zero,
  output logic              halted,
  input  logic [REG_AW-1:0] dbg_raddr,
  output logic [DATA_W-1:0] dbg_rdata
);

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [2:0]        op;
    logic [REG_AW-1:0] rd;
    logic              reg_write;
  } idex_t;

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

  logic [DATA_W-1:0] regs [NUM_REGS];
  idex_t             idex;
  logic              idex_v;
  logic              exwb_v;
  logic              exwb_reg_write;
  logic [REG_AW-1:0] exwb_rd;
  logic [DATA_W-1:0] exwb_data;
  logic [DATA_W-1:0] alu_res;
  logic [DATA_W-1:0] imm_ext;
  logic [REG_AW-1:0] src [2];
  logic [DATA_W-1:0] opnd [2];
  logic              accept;
  state_t            state;

  assign accept  = in_valid & in_ready;
  assign imm_ext = {{(DATA_W-IMM_W){in_imm[IMM_W-1]}}, in_imm};
  assign src[0]  = in_rs;
  assign src[1]  = in_rt;

  // EX result takes priority over WB: it is the younger producer of the same register.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      opnd[i] = regs[src[i]];
      if (src[i] == '0)
        opnd[i] = '0;
      else if (idex_v && idex.reg_write && idex.rd == src[i])
        opnd[i] = alu_res;
      else if (exwb_v && exwb_reg_write && exwb_rd == src[i])
        opnd[i] = exwb_data;
    end
  end

  always_comb begin
    alu_res = '0;
    case (idex.op)
      3'd0:    alu_res = idex.a + idex.b;
      3'd1:    alu_res = idex.a - idex.b;
      3'd2:    alu_res = idex.a & idex.b;
      3'd3:    alu_res = idex.a | idex.b;
      3'd4:    alu_res = ~(idex.a | idex.b);
      3'd5:    alu_res = ~(idex.a & idex.b);
      3'd6:    alu_res = {{(DATA_W-1){1'b0}}, ($signed(idex.a) < $signed(idex.b))};
      default: alu_res = '0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      idex           <= '0;
      idex_v         <= 1'b0;
      exwb_v         <= 1'b0;
      exwb_reg_write <= 1'b0;
      exwb_rd        <= '0;
      exwb_data      <= '0;
      state          <= RUN;
      in_ready       <= 1'b1;
      halted         <= 1'b0;
    end else begin
      exwb_v         <= idex_v;
      exwb_data      <= alu_res;
      exwb_rd        <= idex.rd;
      exwb_reg_write <= idex.reg_write;
      if (exwb_v && exwb_reg_write && exwb_rd != '0)
        regs[exwb_rd] <= exwb_data;

      idex_v <= accept && !in_halt;
      if (accept && !in_halt)
        idex <= '{a: opnd[0], b: (in_use_imm ? imm_ext : opnd[1]),
                  op: in_alu_op, rd: in_rd, reg_write: in_reg_write};

      case (state)
        RUN: if (accept && in_halt) begin
          state    <= DRAIN;
          in_ready <= 1'b0;
        end
        DRAIN: if (!idex_v && !exwb_v) begin
          state  <= HALTED;
          halted <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign wb_valid  = exwb_v;
  assign wb_rd     = exwb_rd;
  assign wb_data   = exwb_data;
  assign wb_zero   = (exwb_data == '0);
  assign dbg_rdata = regs[dbg_raddr];

endmodule
